pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//   Program-counter generator for the pipelined CPU fetch stage. Holds the current PC,
//   selects next PC from reset, exception vector, resolved redirect, stall hold, return
//   prediction or sequential increment. Adds a small return-address stack (RAS) that
//   predicts targets of function returns. Output pc drives the instruction memory address.
// PARAMETERS
//   PC_WIDTH     32            width of pc, targets and RAS entries
//   RESET_PC     32'h0000_0000 value loaded on reset
//   EXC_VECTOR   32'h8000_0180 value loaded on exception
//   INSTR_BYTES  4             sequential increment
//   RAS_DEPTH    4             RAS entries (power of 2, >=2)
// PORTS
//   clock            in   1         rising-edge clock
//   reset            in   1         synchronous, active-high
//   pc_write         in   1         1 = PC may advance; 0 = hazard stall (hold)
//   exc_req          in   1         exception taken this cycle
//   redirect_valid   in   1         branch/jump resolved, mispredict or taken
//   redirect_target  in   PC_WIDTH  resolved target
//   is_call          in   1         instruction at pc is a call (jal/jalr link)
//   is_ret           in   1         instruction at pc is a return (jr $ra)
//   pc               out  PC_WIDTH  current fetch address (registered)
//   pc_plus          out  PC_WIDTH  pc + INSTR_BYTES (combinational)
//   ras_empty        out  1         RAS holds 0 entries
//   ras_full         out  1         RAS holds RAS_DEPTH entries
//   ras_overflow     out  1         one-cycle pulse: push onto full stack
// BEHAVIOUR
//   Reset (sync, highest priority): pc<=RESET_PC, RAS count<=0, ras_overflow<=0.
//   Reset outputs: pc=RESET_PC, ras_empty=1, ras_full=0, ras_overflow=0.
//   Next-pc priority per rising edge (first match wins):
//     1 exc_req        -> pc<=EXC_VECTOR; RAS cleared (count<=0). Overrides stall.
//     2 redirect_valid -> pc<=redirect_target; RAS untouched. Overrides stall.
//     3 !pc_write      -> pc holds; no RAS push/pop.
//     4 is_ret & !empty-> pc<=RAS top; pop.
//     5 otherwise      -> pc<=pc_plus (includes is_ret on empty RAS).
//   Latency: one cycle; new pc visible the cycle after the selecting edge.
//   Arithmetic: pc_plus = pc + INSTR_BYTES modulo 2^PC_WIDTH (wraps to 0, no flag).
//   RAS push: is_call, case 4/5 path only -> push pc_plus.
//   Simultaneous is_call & is_ret (case 4): pop then push; count unchanged,
//     top replaced by pc_plus, next pc = old top.
//   Push when full: oldest entry overwritten (circular), count stays RAS_DEPTH,
//     ras_overflow pulses 1 for one cycle.
//   Pop when empty: no pop, count stays 0, pc advances sequentially.
//   Stall, redirect or exception suppress push/pop in that cycle.
//   Reset asserted mid-operation discards everything on that edge.
// STRUCTURE
//   Shared package: PC_WIDTH, RESET_PC, EXC_VECTOR, INSTR_BYTES constants and
//   next-pc select encoding (SEL_EXC, SEL_REDIR, SEL_HOLD, SEL_RAS, SEL_SEQ).
//   Sub-module ras_stack: circular buffer + top pointer + count; ports push,
//   pop, push_data, top_data, clear, empty, full, overflow. Top level holds the pc
//   register and next-pc priority mux.
// TESTING
//   Reset then 3 free cycles, pc_write=1 -> pc = 0, 4, 8, 12.
//   pc=0x10, pc_write=0 for 2 cycles -> pc stays 0x10; release -> 0x14.
//   pc_write=0 and redirect_valid, target 0x400 -> next pc=0x400 (redirect beats stall).
//   call at 0x20, call at 0x100, ret at 0x200, ret at 0x30 -> pc after rets = 0x104, 0x24.
//   5 calls with RAS_DEPTH=4 -> ras_overflow pulses on 5th; 4 rets return newest 4 only.
//   exc_req together with redirect and is_ret -> pc=EXC_VECTOR, ras_empty=1 next cycle.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// Shared constants and next-pc select encoding for the fetch-stage program counter.
package pc_unit_pkg;

   localparam int              PC_WIDTH    = 32;
   localparam logic [31:0]     RESET_PC    = 32'h0000_0000;
   localparam logic [31:0]     EXC_VECTOR  = 32'h8000_0180;
   localparam int              INSTR_BYTES = 4;
   localparam int              RAS_DEPTH   = 4;

   typedef enum logic [2:0] {
      SEL_EXC   = 3'd0,
      SEL_REDIR = 3'd1,
      SEL_HOLD  = 3'd2,
      SEL_RAS   = 3'd3,
      SEL_SEQ   = 3'd4
   } pc_sel_e;

endpackage

// File: rtl/pc_unit_ras_stack.sv
// Return-address stack: circular buffer with a top pointer and an occupancy count.
module ras_stack #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic         clear,
   input  logic [W-1:0] push_data,
   output logic [W-1:0] top_data,
   output logic         empty,
   output logic         full,
   output logic         overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_top;
   logic [CW-1:0] r_count;
   logic          r_ovf;

   logic          w_pop_ok;
   logic          w_push_only;
   logic          w_swap;
   logic [PW-1:0] w_top_inc;

   assign empty     = (r_count == '0);
   assign full      = (r_count == CW'(DEPTH));
   assign overflow  = r_ovf;
   assign top_data  = r_mem[r_top];

   // A pop on an empty stack is ignored; pop+push replaces the top in place.
   assign w_pop_ok    = pop & ~empty;
   assign w_push_only = push & ~w_pop_ok;
   assign w_swap      = push & w_pop_ok;
   assign w_top_inc   = r_top + PW'(1);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_top   <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else if (clear) begin
         r_top   <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_ovf <= w_push_only & full;
         if (w_push_only) begin
            // When full, top+1 is the oldest entry, so it is overwritten.
            r_top <= w_top_inc;
            if (!full) r_count <= r_count + CW'(1);
         end else if (w_pop_ok && !push) begin
            r_top   <= r_top - PW'(1);
            r_count <= r_count - CW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!clear) begin
         if (w_push_only)
            r_mem[w_top_inc] <= push_data;
         else if (w_swap)
            r_mem[r_top] <= push_data;
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter: registered pc, next-pc priority mux and return-address prediction.
module pc_unit #(
   parameter int                  PC_WIDTH    = pc_unit_pkg::PC_WIDTH,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = pc_unit_pkg::RESET_PC,
   parameter logic [PC_WIDTH-1:0] EXC_VECTOR  = pc_unit_pkg::EXC_VECTOR,
   parameter int                  INSTR_BYTES = pc_unit_pkg::INSTR_BYTES,
   parameter int                  RAS_DEPTH   = pc_unit_pkg::RAS_DEPTH
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                pc_write,
   input  logic                exc_req,
   input  logic                redirect_valid,
   input  logic [PC_WIDTH-1:0] redirect_target,
   input  logic                is_call,
   input  logic                is_ret,
   output logic [PC_WIDTH-1:0] pc,
   output logic [PC_WIDTH-1:0] pc_plus,
   output logic                ras_empty,
   output logic                ras_full,
   output logic                ras_overflow
);

   import pc_unit_pkg::*;

   logic [PC_WIDTH-1:0] r_pc;
   logic [PC_WIDTH-1:0] w_pc_plus;
   logic [PC_WIDTH-1:0] w_ras_top;
   logic                w_ras_empty;
   logic                w_push;
   logic                w_pop;
   logic                w_clear;
   pc_sel_e             w_sel;

   assign w_pc_plus = r_pc + PC_WIDTH'(INSTR_BYTES);
   assign pc        = r_pc;
   assign pc_plus   = w_pc_plus;
   assign ras_empty = w_ras_empty;

   always_comb begin
      w_sel = SEL_SEQ;
      if (exc_req)
         w_sel = SEL_EXC;
      else if (redirect_valid)
         w_sel = SEL_REDIR;
      else if (!pc_write)
         w_sel = SEL_HOLD;
      else if (is_ret && !w_ras_empty)
         w_sel = SEL_RAS;
   end

   // Only the instruction actually advancing sequentially or by return may touch the stack.
   assign w_pop   = (w_sel == SEL_RAS);
   assign w_push  = is_call & ((w_sel == SEL_RAS) | (w_sel == SEL_SEQ));
   assign w_clear = (w_sel == SEL_EXC);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_pc <= RESET_PC;
      end else begin
         case (w_sel)
            SEL_EXC:   r_pc <= EXC_VECTOR;
            SEL_REDIR: r_pc <= redirect_target;
            SEL_HOLD:  r_pc <= r_pc;
            SEL_RAS:   r_pc <= w_ras_top;
            default:   r_pc <= w_pc_plus;
         endcase
      end
   end

   ras_stack #(
      .W     (PC_WIDTH),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clock     (clock),
      .reset     (reset),
      .push      (w_push),
      .pop       (w_pop),
      .clear     (w_clear),
      .push_data (w_pc_plus),
      .top_data  (w_ras_top),
      .empty     (w_ras_empty),
      .full      (ras_full),
      .overflow  (ras_overflow)
   );

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: driver feeds a queue-based reference model, monitor compares.
module tb_pc_unit;

   localparam int          W      = 32;
   localparam int          D      = 4;
   localparam logic [W-1:0] RST_PC = 32'h0000_0000;
   localparam logic [W-1:0] EXC_PC = 32'h8000_0180;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         pc_write = 1'b1;
   logic         exc_req = 1'b0;
   logic         redirect_valid = 1'b0;
   logic [W-1:0] redirect_target = '0;
   logic         is_call = 1'b0;
   logic         is_ret = 1'b0;
   logic [W-1:0] pc;
   logic [W-1:0] pc_plus;
   logic         ras_empty;
   logic         ras_full;
   logic         ras_overflow;

   pc_unit dut (
      .clock           (clock),
      .reset           (reset),
      .pc_write        (pc_write),
      .exc_req         (exc_req),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .is_call         (is_call),
      .is_ret          (is_ret),
      .pc              (pc),
      .pc_plus         (pc_plus),
      .ras_empty       (ras_empty),
      .ras_full        (ras_full),
      .ras_overflow    (ras_overflow)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [W-1:0] pc;
      logic         empty;
      logic         full;
      logic         ovf;
   } exp_t;

   exp_t         sb[$];
   logic [W-1:0] m_pc;
   logic [W-1:0] m_ras[$];
   logic         m_ovf;
   int           n_tests = 0;
   int           n_fail  = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One fetch cycle: drive inputs, advance the reference model, queue the expected state.
   task automatic cyc(input logic rst, input logic pcw, input logic exc, input logic rv,
                      input logic [W-1:0] tgt, input logic call, input logic ret);
      exp_t         e;
      logic [W-1:0] seq;
      @(negedge clock);
      reset = rst; pc_write = pcw; exc_req = exc; redirect_valid = rv;
      redirect_target = tgt; is_call = call; is_ret = ret;
      m_ovf = 1'b0;
      if (rst) begin
         m_pc = RST_PC;
         m_ras.delete();
      end else if (exc) begin
         m_pc = EXC_PC;
         m_ras.delete();
      end else if (rv) begin
         m_pc = tgt;
      end else if (pcw) begin
         seq = m_pc + 32'd4;
         if (ret && m_ras.size() > 0) m_pc = m_ras.pop_back();
         else                         m_pc = seq;
         if (call) begin
            m_ras.push_back(seq);
            if (m_ras.size() > D) begin
               m_ras.delete(0);
               m_ovf = 1'b1;
            end
         end
      end
      e.pc    = m_pc;
      e.empty = (m_ras.size() == 0);
      e.full  = (m_ras.size() == D);
      e.ovf   = m_ovf;
      sb.push_back(e);
   endtask

   task automatic run(input logic call, input logic ret);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, call, ret);
   endtask

   task automatic jump(input logic [W-1:0] tgt);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, tgt, 1'b0, 1'b0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pc",           pc,                 e.pc);
            chk("pc_plus",      pc_plus,            e.pc + 32'd4);
            chk("ras_empty",    {31'd0, ras_empty}, {31'd0, e.empty});
            chk("ras_full",     {31'd0, ras_full},  {31'd0, e.full});
            chk("ras_overflow", {31'd0, ras_overflow}, {31'd0, e.ovf});
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got %0d pending expected 0", sb.size());
      $fatal(1, "timeout");
   end

   initial begin : driver
      logic r, pw, ex, rv, ca, rt;
      cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      repeat (3) run(1'b0, 1'b0);

      jump(32'h10);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
      run(1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h400, 1'b0, 1'b0);

      jump(32'h20);  run(1'b1, 1'b0);
      jump(32'h100); run(1'b1, 1'b0);
      jump(32'h200); run(1'b0, 1'b1);
      jump(32'h30);  run(1'b0, 1'b1);
      run(1'b0, 1'b1);

      cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      repeat (5) run(1'b1, 1'b0);
      repeat (5) run(1'b0, 1'b1);

      run(1'b1, 1'b0); run(1'b1, 1'b0);
      run(1'b1, 1'b1);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h500, 1'b0, 1'b1);
      run(1'b0, 1'b1);

      jump(32'hFFFF_FFF8);
      run(1'b0, 1'b0); run(1'b1, 1'b0); run(1'b0, 1'b1);

      run(1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);

      for (int i = 0; i < 3000; i++) begin
         r  = ($urandom_range(0, 127) == 0);
         ex = ($urandom_range(0, 39) == 0);
         rv = ($urandom_range(0, 7) == 0);
         pw = ($urandom_range(0, 6) != 0);
         ca = ($urandom_range(0, 2) == 0);
         rt = ($urandom_range(0, 3) == 0);
         cyc(r, pw, ex, rv, $urandom() & 32'hFFFF_FFFC, ca, rt);
      end

      @(negedge clock);
      reset = 1'b0; pc_write = 1'b0; exc_req = 1'b0; redirect_valid = 1'b0;
      is_call = 1'b0; is_ret = 1'b0;
      @(posedge clock);
      #2;
      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
